wb_regfile_scoreboard: RTL and testbench

- Architectural register file. It is the receiving end of the write-back pipeline register: it consumes result, destination address and write enable each cycle and commits them to the 32 GPRs.
- Provides two combinational read ports to the decode stage, with write-back bypass.
- Holds a per-register pending-write scoreboard. Decode sets an entry at issue, write-back clears it, and decode sees busy flags for stall decisions.

---
 rtl/wb_regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_wb_regfile_scoreboard.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_scoreboard.sv
// Architectural GPR file with write-back commit, two bypassed combinational read
// ports and a per-register pending-write scoreboard for decode stall decisions.
module wb_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              err_o
);

  localparam int                NREG    = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic              err_q, err_d;

  logic [NREG-1:0]   inc_vec, dec_vec;
  logic              wb_commit;
  logic              err_set;

  assign wb_commit = wb_en_i && (wb_addr_i != '0);

  // Per-register increment/decrement requests; register 0 never participates.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = issue_en_i && (issue_addr_i == ADDR_W'(r));
      dec_vec[r] = wb_en_i && (wb_addr_i == ADDR_W'(r));
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      gpr_d[r] = gpr_q[r];
    end
    if (wb_commit) begin
      gpr_d[wb_addr_i] = wb_data_i;
    end
  end

  // Flush wipes all counts and masks both the same-cycle issue and decrement.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0 || flush_i) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
    err_d = err_q || err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        gpr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        gpr_q[r] <= gpr_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    if (addr == '0) begin
      return '0;
    end
    if (wb_en_i && (wb_addr_i == addr)) begin
      return wb_data_i;
    end
    return stored;
  endfunction

  // A register whose final writer commits this cycle is served by the bypass.
  function automatic logic busy_flag(
    input logic [ADDR_W-1:0] addr,
    input logic [PEND_W-1:0] cnt
  );
    logic last_commit;
    last_commit = (cnt == CNT_ONE) && wb_en_i && (wb_addr_i == addr);
    return (addr != '0) && (cnt != '0) && !last_commit;
  endfunction

  always_comb begin
    rs_data_o = read_port(rs_addr_i, gpr_q[rs_addr_i]);
    rt_data_o = read_port(rt_addr_i, gpr_q[rt_addr_i]);
    rs_busy_o = busy_flag(rs_addr_i, cnt_q[rs_addr_i]);
    rt_busy_o = busy_flag(rt_addr_i, cnt_q[rt_addr_i]);
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Table-driven bench: each row drives one cycle of inputs and its expected
// combinational outputs go through a queue and are checked mid-cycle.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_data_i;
  logic [4:0]  wb_addr_i;
  logic        wb_en_i;
  logic [4:0]  rs_addr_i, rt_addr_i;
  logic [31:0] rs_data_o, rt_data_o;
  logic        rs_busy_o, rt_busy_o;
  logic        issue_en_i;
  logic [4:0]  issue_addr_i;
  logic        flush_i;
  logic        err_o;

  wb_regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_en_i(wb_en_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o),
    .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i),
    .flush_i(flush_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        chk;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_rsb;
    logic        e_rtb;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void v(
    input logic rst_v, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
    input logic ien, input logic [4:0] ia, input logic fl,
    input logic [4:0] rs, input logic [4:0] rt, input logic chk,
    input logic [31:0] ers, input logic [31:0] ert,
    input logic ersb, input logic ertb, input logic eerr
  );
    vec_t x;
    x = '{rst_v, wen, wa, wd, ien, ia, fl, rs, rt, chk, ers, ert, ersb, ertb, eerr};
    tbl.push_back(x);
  endfunction

  task automatic check32(input int row, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %08h want %08h", row, name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t cur, e;
    rst = 1'b0; wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; issue_en_i = 0; issue_addr_i = 0; flush_i = 0;

    //  rst wen wa  wdata          ien ia fl rs  rt chk e_rs           e_rt           rsb rtb err
    v(0, 0, 0,  32'h0,          0, 0, 0, 0,  0, 0, 32'h0,          32'h0,          0, 0, 0);
    v(0, 0, 0,  32'h0,          0, 0, 0, 0,  0, 0, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 5, 31, 1, 32'h0,          32'h0,          0, 0, 0);
    // write with bypass, then hold; r0 writes/issues ignored
    v(1, 0, 0,  32'h0,          1, 7, 0, 7,  0, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 1, 7,  32'hDEADBEEF,   0, 0, 0, 7,  7, 1, 32'hDEADBEEF,   32'hDEADBEEF,   0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 7,  0, 1, 32'hDEADBEEF,   32'h0,          0, 0, 0);
    v(1, 1, 0,  32'h12345678,   1, 0, 0, 0,  0, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 0,  7, 1, 32'h0,          32'hDEADBEEF,   0, 0, 0);
    // scoreboard lifecycle on r3
    v(1, 0, 0,  32'h0,          1, 3, 0, 0,  3, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          1, 3, 0, 0,  3, 1, 32'h0,          32'h0,          0, 1, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 0,  3, 1, 32'h0,          32'h0,          0, 1, 0);
    v(1, 1, 3,  32'hA1,         0, 0, 0, 0,  3, 1, 32'h0,          32'hA1,         0, 1, 0);
    v(1, 1, 3,  32'hB2,         0, 0, 0, 3,  3, 1, 32'hB2,         32'hB2,         0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 3,  3, 1, 32'hB2,         32'hB2,         0, 0, 0);
    // simultaneous issue + write-back on r9
    v(1, 0, 0,  32'h0,          1, 9, 0, 9,  0, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 1, 9,  32'h99,         1, 9, 0, 9,  0, 1, 32'h99,         32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 9,  9, 1, 32'h99,         32'h99,         1, 1, 0);
    v(1, 1, 9,  32'h9A,         0, 0, 0, 9,  0, 1, 32'h9A,         32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 9,  0, 1, 32'h9A,         32'h0,          0, 0, 0);
    // flush with same-cycle issue r2 and write-back r8
    v(1, 0, 0,  32'h0,          1, 2, 0, 2,  8, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          1, 2, 0, 2,  8, 1, 32'h0,          32'h0,          1, 0, 0);
    v(1, 0, 0,  32'h0,          1, 8, 0, 2,  8, 1, 32'h0,          32'h0,          1, 0, 0);
    v(1, 1, 8,  32'h55,         1, 2, 1, 2,  8, 1, 32'h0,          32'h55,         1, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 2,  8, 1, 32'h0,          32'h55,         0, 0, 0);
    // underflow error, sticky
    v(1, 1, 12, 32'hC,          0, 0, 0, 12, 0, 1, 32'hC,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 12, 7, 1, 32'hC,          32'hDEADBEEF,   0, 0, 1);
    v(1, 0, 0,  32'h0,          1, 5, 0, 12, 5, 1, 32'hC,          32'h0,          0, 0, 1);
    // reset clears data, counts and error
    v(0, 0, 0,  32'h0,          0, 0, 0, 0,  0, 0, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 7, 12, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 5,  8, 1, 32'h0,          32'h0,          0, 0, 0);
    // saturation on r4, then drain
    v(1, 0, 0,  32'h0,          1, 4, 0, 4,  0, 1, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          1, 4, 0, 4,  0, 1, 32'h0,          32'h0,          1, 0, 0);
    v(1, 0, 0,  32'h0,          1, 4, 0, 4,  0, 1, 32'h0,          32'h0,          1, 0, 0);
    v(1, 0, 0,  32'h0,          1, 4, 0, 4,  4, 1, 32'h0,          32'h0,          1, 1, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 4,  0, 1, 32'h0,          32'h0,          1, 0, 1);
    v(1, 1, 4,  32'h44,         0, 0, 0, 4,  0, 1, 32'h44,         32'h0,          1, 0, 1);
    v(1, 1, 4,  32'h45,         0, 0, 0, 4,  0, 1, 32'h45,         32'h0,          1, 0, 1);
    v(1, 1, 4,  32'h46,         0, 0, 0, 4,  0, 1, 32'h46,         32'h0,          0, 0, 1);
    v(1, 0, 0,  32'h0,          0, 0, 0, 4,  4, 1, 32'h46,         32'h46,         0, 0, 1);
    // reset overrides same-cycle write-back and issue
    v(0, 1, 5,  32'h77,         1, 5, 0, 0,  0, 0, 32'h0,          32'h0,          0, 0, 0);
    v(1, 0, 0,  32'h0,          0, 0, 0, 5,  4, 1, 32'h0,          32'h0,          0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      cur          = tbl[i];
      rst          = cur.rst;
      wb_en_i      = cur.wb_en;
      wb_addr_i    = cur.wb_addr;
      wb_data_i    = cur.wb_data;
      issue_en_i   = cur.iss_en;
      issue_addr_i = cur.iss_addr;
      flush_i      = cur.flush;
      rs_addr_i    = cur.rs;
      rt_addr_i    = cur.rt;
      sb.push_back(cur);
      @(negedge clk);
      e = sb.pop_front();
      if (e.chk) begin
        check32(i, "rs_data", rs_data_o, e.e_rs);
        check32(i, "rt_data", rt_data_o, e.e_rt);
        check32(i, "rs_busy", {31'b0, rs_busy_o}, {31'b0, e.e_rsb});
        check32(i, "rt_busy", {31'b0, rt_busy_o}, {31'b0, e.e_rtb});
        check32(i, "err",     {31'b0, err_o},     {31'b0, e.e_err});
      end
    end

    // err stays set across a long idle stretch until reset
    @(posedge clk); #1;
    wb_en_i = 1; wb_addr_i = 5'd20; wb_data_i = 32'hF0; issue_en_i = 0; flush_i = 0;
    rs_addr_i = 5'd20; rt_addr_i = 5'd0;
    @(posedge clk); #1;
    wb_en_i = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check32(100, "err_sticky", {31'b0, err_o}, 32'd1);
    check32(100, "r20_data", rs_data_o, 32'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
